// File: rtl/vote_controller_if.sv
// Voting station bus: officer/candidate inputs and vote/display outputs.
interface vote_controller_if;
   logic       mode;
   logic       ballot_arm;
   logic       button1;
   logic       button2;
   logic       button3;
   logic       button4;
   logic       cand1_vote_valid;
   logic       cand2_vote_valid;
   logic       cand3_vote_valid;
   logic       cand4_vote_valid;
   logic       ballot_ready;
   logic [7:0] total_ballots;
   logic       ballots_full;
   logic [1:0] disp_sel;

   // Stimulus side: drives the panel inputs, observes the controller.
   modport master (
      output mode, ballot_arm, button1, button2, button3, button4,
      input  cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
      input  ballot_ready, total_ballots, ballots_full, disp_sel
   );

   // Controller side.
   modport slave (
      input  mode, ballot_arm, button1, button2, button3, button4,
      output cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid,
      output ballot_ready, total_ballots, ballots_full, disp_sel
   );
endinterface

// File: rtl/vote_controller.sv
// Ballot controller: synchronizes and debounces four candidate buttons,
// accepts one vote per officer arm, and selects a candidate for display.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no ballot open; in display mode presses select disp_sel
// ARMED    | ballot open, waiting for the first candidate press
// CAST     | one-cycle vote strobe for the winner, count incremented
// WAIT_REL | waiting for every debounced button to be released
module vote_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 10
) (
   input logic              clk,
   input logic              reset,
   vote_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      CAST     = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   state_t     state;
   logic [3:0] btn_raw;
   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [3:0] deb;
   logic [3:0] deb_q;
   logic [3:0] press;
   logic       arm_q;
   logic       arm_rise;
   logic [3:0] vote;
   logic       ready;
   logic [7:0] total;
   logic [1:0] disp;
   logic       full;

   assign btn_raw = {bus.button4, bus.button3, bus.button2, bus.button1};

   // Lowest-numbered pending press wins when several arrive together.
   function automatic logic [1:0] first_idx(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Two-flop synchronizer for the asynchronous buttons.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_db
      logic [15:0] cnt;
      logic        level;

      // Accept a new level only after it has persisted for the full window;
      // any return to the current level restarts the window.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
         end else if (sync2[i] == level) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            cnt   <= '0;
            level <= sync2[i];
         end else begin
            cnt <= cnt + 16'd1;
         end
      end

      assign deb[i] = level;
   end

   // Edge history for press detection and the officer arm button.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_q <= '0;
         arm_q <= 1'b0;
      end else begin
         deb_q <= deb;
         arm_q <= bus.ballot_arm;
      end
   end

   assign press    = deb & ~deb_q;
   assign arm_rise = bus.ballot_arm & ~arm_q;
   assign full     = (total == 8'hFF);

   // Ballot sequencing with registered strobe, ready, count and display select.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         vote  <= '0;
         ready <= 1'b0;
         total <= '0;
         disp  <= '0;
      end else begin
         vote <= '0;
         case (state)
            IDLE: begin
               if (bus.mode && (press != 4'd0)) begin
                  disp <= first_idx(press);
               end
               if (arm_rise && !bus.mode && !full) begin
                  state <= ARMED;
                  ready <= 1'b1;
               end
            end
            ARMED: begin
               if (bus.mode) begin
                  state <= IDLE;
                  ready <= 1'b0;
               end else if (press != 4'd0) begin
                  state <= CAST;
                  ready <= 1'b0;
                  vote  <= press & (~press + 4'd1);
                  if (!full) begin
                     total <= total + 8'd1;
                  end
               end
            end
            CAST: begin
               state <= WAIT_REL;
            end
            WAIT_REL: begin
               if (deb == 4'd0) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cand1_vote_valid = vote[0];
   assign bus.cand2_vote_valid = vote[1];
   assign bus.cand3_vote_valid = vote[2];
   assign bus.cand4_vote_valid = vote[3];
   assign bus.ballot_ready     = ready;
   assign bus.total_ballots    = total;
   assign bus.ballots_full     = full;
   assign bus.disp_sel         = disp;

endmodule

// File: tb/tb_vote_controller.sv
// Bench for vote_controller with a short debounce window. Expected behaviour
// comes from a ballot-level model: a press counts once held for the window,
// the strobe lands a fixed number of edges after the first high sample.
module tb_vote_controller;

   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vote_controller_if bus();

   vote_controller #(.DEBOUNCE_CYCLES(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log: every cycle with any vote strobe, and multi-hot occurrences.
   logic [3:0] sq[$];
   int         cq[$];
   int         multi_hot = 0;
   logic [3:0] mon_v;

   always @(negedge clk) begin
      mon_v = {bus.cand4_vote_valid, bus.cand3_vote_valid,
               bus.cand2_vote_valid, bus.cand1_vote_valid};
      if (mon_v != 4'd0) begin
         sq.push_back(mon_v);
         cq.push_back(cyc);
      end
      if ($countones(mon_v) > 1) multi_hot++;
   end

   // Reference model state.
   bit m_armed;
   int m_total;
   int m_disp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input logic [3:0] m);
      bus.button1 = m[0];
      bus.button2 = m[1];
      bus.button3 = m[2];
      bus.button4 = m[3];
   endtask

   task automatic check_status(input string tag);
      check({tag, ":total"}, bus.total_ballots, m_total);
      check({tag, ":full"},  bus.ballots_full,  (m_total == 255));
      check({tag, ":disp"},  bus.disp_sel,      m_disp);
      check({tag, ":ready"}, bus.ballot_ready,  m_armed);
   endtask

   task automatic arm_pulse(input string tag);
      bus.ballot_arm = 1'b1;
      tick(1);
      bus.ballot_arm = 1'b0;
      if (!bus.mode && m_total < 255) m_armed = 1'b1;
      check({tag, ":ready"}, bus.ballot_ready, m_armed);
      tick(1);
   endtask

   task automatic press_check(input string tag, input logic [3:0] m, input int hold);
      int start;
      bit acc;
      bit vote;
      int w;
      sq.delete();
      cq.delete();
      start = cyc;
      set_btn(m);
      tick(hold);
      set_btn(4'd0);
      tick(12);
      acc  = (hold >= D) && (m != 4'd0);
      w    = lowest(m);
      vote = 1'b0;
      if (acc && m_armed && !bus.mode) begin
         vote    = 1'b1;
         m_armed = 1'b0;
         if (m_total < 255) m_total++;
      end else if (acc && !m_armed && bus.mode) begin
         m_disp = w;
      end
      check({tag, ":nstrobe"}, sq.size(), vote);
      if (vote && sq.size() > 0) begin
         check({tag, ":winner"}, sq[0], 32'(1 << w));
         check({tag, ":latency"}, cq[0], start + D + 3);
      end
      check_status(tag);
   endtask

   logic [3:0] rm;
   int         start_c;

   initial begin
      reset = 1'b0;
      bus.mode = 1'b0;
      bus.ballot_arm = 1'b0;
      set_btn(4'd0);
      m_armed = 1'b0;
      m_total = 0;
      m_disp  = 0;
      tick(2);
      check_status("reset");
      check("reset:strobes", {bus.cand4_vote_valid, bus.cand3_vote_valid,
                              bus.cand2_vote_valid, bus.cand1_vote_valid}, 0);
      reset = 1'b1;
      tick(2);

      // Single clean vote for candidate 2.
      arm_pulse("v2_arm");
      press_check("v2", 4'b0010, 6);

      // Simultaneous button1 and button3: candidate 1 wins.
      arm_pulse("v13_arm");
      press_check("v13", 4'b0101, 5);

      // Short glitch ignored, then a real press on button4.
      arm_pulse("v4_arm");
      press_check("v4_glitch", 4'b1000, 3);
      press_check("v4", 4'b1000, 10);

      // Press without re-arming.
      press_check("noarm", 4'b0001, 6);

      // Cancel by display mode, then select candidate 3 for display.
      arm_pulse("cancel_arm");
      bus.mode = 1'b1;
      tick(1);
      m_armed = 1'b0;
      check("cancel:ready", bus.ballot_ready, 0);
      press_check("disp3", 4'b0100, 6);
      arm_pulse("disp_arm_ignored");
      press_check("disp1", 4'b0011, 5);
      bus.mode = 1'b0;
      tick(1);

      // Randomized ballots, some preceded by a sub-window glitch.
      for (int k = 0; k < 20; k++) begin
         rm = 4'($urandom_range(1, 15));
         arm_pulse("rnd_arm");
         if ($urandom_range(0, 1) == 1) press_check("rnd_glitch", rm, $urandom_range(1, D - 1));
         press_check("rnd_vote", rm, $urandom_range(D, D + 6));
      end

      // Fill the count to saturation.
      while (m_total < 255) begin
         arm_pulse("fill_arm");
         press_check("fill", 4'(1 << $urandom_range(0, 3)), D);
      end
      check("full:flag", bus.ballots_full, 1);
      arm_pulse("full_arm");
      press_check("full_press", 4'b0010, 6);

      // Reset in the middle of a debounce while armed.
      bus.mode = 1'b1;
      press_check("predisp", 4'b1000, 5);
      bus.mode = 1'b0;
      tick(1);
      arm_pulse("rstdb_arm");
      set_btn(4'b0100);
      tick(2);
      reset = 1'b0;
      #1;
      m_armed = 1'b0;
      m_total = 0;
      m_disp  = 0;
      check_status("rstdb");
      check("rstdb:strobes", {bus.cand4_vote_valid, bus.cand3_vote_valid,
                              bus.cand2_vote_valid, bus.cand1_vote_valid}, 0);
      tick(1);
      reset = 1'b1;
      sq.delete();
      tick(15);
      check("rstdb_hold:nstrobe", sq.size(), 0);
      check_status("rstdb_hold");
      set_btn(4'd0);
      tick(12);

      // Button held through reset release selects display in mode 1.
      bus.mode = 1'b1;
      set_btn(4'b1000);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      sq.delete();
      tick(12);
      m_disp = 3;
      check("heldrst:nstrobe", sq.size(), 0);
      check_status("heldrst");
      set_btn(4'd0);
      tick(12);
      bus.mode = 1'b0;
      tick(1);

      // Reset during the cast cycle.
      arm_pulse("rstcast_arm");
      sq.delete();
      start_c = cyc;
      set_btn(4'b0010);
      tick(D + 3);
      check("rstcast:strobe_before", bus.cand2_vote_valid, 1);
      check("rstcast:cycle", cyc, start_c + D + 3);
      reset = 1'b0;
      #1;
      m_armed = 1'b0;
      m_total = 0;
      m_disp  = 0;
      check("rstcast:strobe_after", bus.cand2_vote_valid, 0);
      check_status("rstcast");
      set_btn(4'd0);
      tick(1);
      reset = 1'b1;
      tick(12);
      check("rstcast:nstrobe", sq.size(), 1);
      check_status("rstcast_end");

      check("one_hot", multi_hot, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vote_controller.md
VOTE_CONTROLLER -- requirements
Module: vote_controller

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 10, giving the stable-input cycles required to accept a button level change (legal range 2..65535).
REQ-002 The module SHALL have the port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have the port mode, input, 1 bit: 0 selects voting, 1 selects result display.
REQ-005 The module SHALL have the port ballot_arm, input, 1 bit: officer button that enables one ballot, synchronous level.
REQ-006 The module SHALL have the ports button1..button4, inputs, 1 bit each: raw asynchronous candidate buttons.
REQ-007 The module SHALL have the ports cand1_vote_valid..cand4_vote_valid, outputs, 1 bit each: single-cycle vote strobes.
REQ-008 The module SHALL have the port ballot_ready, output, 1 bit: high while a ballot is armed.
REQ-009 The module SHALL have the port total_ballots, output, 8 bits: count of votes cast.
REQ-010 The module SHALL have the port ballots_full, output, 1 bit: high when total_ballots equals 255.
REQ-011 The module SHALL have the port disp_sel, output, 2 bits: candidate index (0..3) selected for result display.

Function
REQ-012 Each buttonN SHALL pass through a 2-flop synchronizer, then a debouncer with a 16-bit counter; the debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles, and the counter SHALL clear on any glitch.
REQ-013 A press event SHALL be a rising edge of a debounced level; falling edges SHALL generate no event.
REQ-014 The FSM SHALL have the states IDLE, ARMED, CAST and WAIT_REL, encoded in 2 bits.
REQ-015 IDLE->ARMED SHALL occur on a rising edge of ballot_arm when mode=0 and ballots_full=0; otherwise IDLE SHALL hold.
REQ-016 ARMED->CAST SHALL occur on any press event while mode=0; with simultaneous press events, the lowest-numbered button SHALL win and the others SHALL be discarded.
REQ-017 In CAST, exactly one candN_vote_valid (the winner) SHALL be high for exactly one cycle; total_ballots SHALL increment by 1 (saturating at 255); the next state SHALL be WAIT_REL.
REQ-018 WAIT_REL->IDLE SHALL occur when all four debounced levels are 0; press events and ballot_arm SHALL be ignored in WAIT_REL.
REQ-019 mode=1 in ARMED SHALL force ARMED->IDLE at the next edge with no vote cast (ballot cancelled); CAST SHALL always complete to WAIT_REL regardless of mode.
REQ-020 ballot_ready SHALL be 1 exactly when the state is ARMED.
REQ-021 When mode=1 and the state is IDLE, a press event on buttonN SHALL load disp_sel with N-1 (lowest index wins when simultaneous); otherwise disp_sel SHALL hold.
REQ-022 Latency SHALL be exact: with a clean press while ARMED, candN_vote_valid SHALL be high in the cycle following the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples buttonN high as edge 1.
REQ-023 No more than one candN_vote_valid SHALL ever be high in any cycle, and at most one strobe SHALL occur per ballot_arm rising edge.
REQ-024 ballots_full SHALL be combinational from total_ballots; ballot_arm SHALL be ignored while ballots_full=1.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) force: state IDLE; all candN_vote_valid 0; ballot_ready 0; total_ballots 0; ballots_full 0; disp_sel 0; synchronizers, debounced levels, debounce counters and the ballot_arm edge register 0.
REQ-026 A button held high through reset release SHALL debounce to 1 and produce one press event, which SHALL be ignored unless the state is ARMED (voting) or IDLE with mode=1 (display).
REQ-027 Reset asserted in CAST SHALL suppress the strobe and leave total_ballots at 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Scenario: reset, mode=0, pulse ballot_arm, hold button2 high -> ballot_ready=1; cand2_vote_valid high for 1 cycle after edge 7; total_ballots=1; state returns to IDLE after button2 is released and debounced.
REQ-029 Scenario: in ARMED, button1 and button3 rise on the same edge -> only cand1_vote_valid pulses, total_ballots increments by 1, and no cand3 strobe appears.
REQ-030 Scenario: in ARMED, button4 glitches high for 3 cycles -> no strobe and the state stays ARMED; a following 10-cycle press -> cand4_vote_valid pulses.
REQ-031 Scenario: in ARMED, set mode=1 -> next cycle ballot_ready=0; a subsequent button3 press -> disp_sel=2 and no strobe.
REQ-032 Scenario: a second press without re-arming after a vote -> no strobe; drive 255 armed votes -> ballots_full=1, and further ballot_arm leaves ballot_ready=0 with total_ballots=255.
REQ-033 Scenario: assert reset mid-debounce while ARMED -> all outputs 0 immediately; after release with no ballot_arm, a held button produces no strobe.
